regfile32: RTL and testbench
============================

# regfile32

MIPS general-purpose register file: 32 × 32-bit registers, one write port and two synchronous read ports with write-to-read bypass. It sits in the datapath between decode (rs/rt addresses) and the ALU operand registers, and is the read-side counterpart to the enable-gated register elements that hold pipeline state. A per-register "written since reset" bitmap flags reads of uninitialised registers for debug and verification.

## Interface
- REG_W, 32, data width of each register
- REG_N, 32, number of registers (address width derived as 5)
- clk_in  input  1  clock; all state updates on rising edge
- rst_in  input  1  asynchronous, active-low reset
- we  input  1  write enable
- wa  input  5  write address
- wd  input  32  write data
- re1  input  1  read-port-1 enable
- ra1  input  5  read-port-1 address
- rd1  output  32  read-port-1 data, registered
- rd1_unwr  output  1  port-1 data came from a never-written register
- re2  input  1  read-port-2 enable
- ra2  input  5  read-port-2 address
- rd2  output  32  read-port-2 data, registered
- rd2_unwr  output  1  port-2 data came from a never-written register

## Operation
- Reset (rst_in = 0, async): registers 1..31 ← 0; rd1, rd2 ← 0; rd1_unwr, rd2_unwr ← 0; written bitmap ← 0 except bit 0.
- Register 0 is hardwired zero: writes with wa = 0 are ignored, do not set bitmap bit 0 (already 1), and any read of address 0 returns 0 with unwr = 0.
- Write: on a rising edge with we = 1 and wa ≠ 0, reg[wa] ← wd and written[wa] ← 1.
- Read port k (k = 1, 2): on a rising edge with rek = 1:
  - rak = 0 → rdk ← 0, rdk_unwr ← 0.
  - else if we = 1 and wa = rak → rdk ← wd (bypass), rdk_unwr ← 0.
  - else → rdk ← reg[rak], rdk_unwr ← ~written[rak].
- rek = 0: rdk and rdk_unwr hold their previous values.
- Both ports are independent; same address on both ports returns identical data and flags.
- No arithmetic; all widths exact, no truncation.

## Timing
- Write latency: data is visible to a non-bypassed read issued on the following edge.
- Read latency: 1 cycle; address sampled at edge N, data valid after edge N, held until the next enabled read.
- Same-cycle write + read of the same nonzero address: read returns new wd (write-first).
- Simultaneous write and reset: reset wins; the register stays 0 and the bitmap stays clear.
- Reset asserted mid-operation clears outputs immediately (asynchronously), not at the next edge; the first enabled read after deassertion returns 0 with unwr = 1 for any nonzero address.
- Inputs must be stable around the rising edge; no combinational path from inputs to outputs.

## Structure
- Shared package mips_pkg: REG_W, REG_N, REG_AW = 5, typedefs word_t (logic [31:0]) and reg_addr_t (logic [4:0]).
- Storage array and written bitmap live in regfile32.
- One sub-module, regfile_rdport: address decode, bypass mux, zero-register handling, output and flag registers; instantiated twice.

## Test plan
- Reset then read ra1 = 5, ra2 = 0 with re1 = re2 = 1 → rd1 = 0, rd1_unwr = 1; rd2 = 0, rd2_unwr = 0.
- Write wa = 7, wd = 32'hDEADBEEF; next cycle read ra1 = 7 → rd1 = 32'hDEADBEEF, rd1_unwr = 0.
- Same-cycle we = 1, wa = 3, wd = 32'h12345678 with ra1 = ra2 = 3 → both ports = 32'h12345678 after the edge, both unwr = 0.
- Write wa = 0, wd = 32'hFFFFFFFF; then read ra1 = 0 → rd1 = 0, rd1_unwr = 0.
- Read ra1 = 7 (holding 32'hDEADBEEF), then re1 = 0 and ra1 = 3 for 3 cycles → rd1 remains 32'hDEADBEEF.
- Write regs 1..31 with value = address, then pulse rst_in low between edges → rd1/rd2 drop to 0 immediately; subsequent read of 31 returns 0 with unwr = 1.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared datapath types and sizing for the MIPS integer register file.
package mips_pkg;

    localparam int REG_W  = 32;
    localparam int REG_N  = 32;
    localparam int REG_AW = 5;

    typedef logic [REG_W-1:0]  word_t;
    typedef logic [REG_AW-1:0] reg_addr_t;

    // A same-edge write to a live register forwards straight into a read.
    function automatic logic wr_hits(input logic we, input reg_addr_t wa, input reg_addr_t ra);
        return we && (wa == ra) && (ra != '0);
    endfunction

endpackage

// File: rtl/regfile_rdport.sv
// One synchronous read port: register select, write-first bypass, r0 forced zero,
// registered data plus an "uninitialised source" flag.
module regfile_rdport
    import mips_pkg::*;
(
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        re_i,
    input  reg_addr_t                   ra_i,
    input  logic                        we_i,
    input  reg_addr_t                   wa_i,
    input  word_t                       wd_i,
    input  logic [REG_N-1:0][REG_W-1:0] regs_i,
    input  logic [REG_N-1:0]            written_i,
    output word_t                       rd_o,
    output logic                        unwr_o
);

    word_t rd_q, rd_d;
    logic  unwr_q, unwr_d;

    always_comb begin
        rd_d   = rd_q;
        unwr_d = unwr_q;
        if (re_i) begin
            if (ra_i == '0) begin
                rd_d   = '0;
                unwr_d = 1'b0;
            end else if (wr_hits(we_i, wa_i, ra_i)) begin
                rd_d   = wd_i;
                unwr_d = 1'b0;
            end else begin
                rd_d   = regs_i[ra_i];
                unwr_d = ~written_i[ra_i];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_q   <= '0;
            unwr_q <= 1'b0;
        end else begin
            rd_q   <= rd_d;
            unwr_q <= unwr_d;
        end
    end

    assign rd_o   = rd_q;
    assign unwr_o = unwr_q;

endmodule

// File: rtl/regfile32.sv
// 32x32 MIPS register file: one write port, two registered read ports with bypass,
// and a written-since-reset bitmap for catching reads of uninitialised registers.
module regfile32
    import mips_pkg::*;
(
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              we,
    input  logic [REG_AW-1:0] wa,
    input  logic [REG_W-1:0]  wd,
    input  logic              re1,
    input  logic [REG_AW-1:0] ra1,
    output logic [REG_W-1:0]  rd1,
    output logic              rd1_unwr,
    input  logic              re2,
    input  logic [REG_AW-1:0] ra2,
    output logic [REG_W-1:0]  rd2,
    output logic              rd2_unwr
);

    logic [REG_N-1:0][REG_W-1:0] regs_q, regs_d;
    logic [REG_N-1:0]            written_q, written_d;

    always_comb begin
        regs_d    = regs_q;
        written_d = written_q;
        if (we && wa != '0) begin
            regs_d[wa]    = wd;
            written_d[wa] = 1'b1;
        end
    end

    // r0 is never written, so it stays at its reset value of zero; its bitmap bit
    // comes out of reset set so it never reports as uninitialised.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            regs_q    <= '0;
            written_q <= REG_N'(1);
        end else begin
            regs_q    <= regs_d;
            written_q <= written_d;
        end
    end

    regfile_rdport u_rdport1 (
        .clk_i     (clk_in),
        .rst_ni    (rst_in),
        .re_i      (re1),
        .ra_i      (ra1),
        .we_i      (we),
        .wa_i      (wa),
        .wd_i      (wd),
        .regs_i    (regs_q),
        .written_i (written_q),
        .rd_o      (rd1),
        .unwr_o    (rd1_unwr)
    );

    regfile_rdport u_rdport2 (
        .clk_i     (clk_in),
        .rst_ni    (rst_in),
        .re_i      (re2),
        .ra_i      (ra2),
        .we_i      (we),
        .wa_i      (wa),
        .wd_i      (wd),
        .regs_i    (regs_q),
        .written_i (written_q),
        .rd_o      (rd2),
        .unwr_o    (rd2_unwr)
    );

endmodule

// File: tb/tb_regfile32.sv
// Scenario tasks plus randomized traffic checked against an array-based model.
module tb_regfile32;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        re1;
    logic [4:0]  ra1;
    logic [31:0] rd1;
    logic        rd1_unwr;
    logic        re2;
    logic [4:0]  ra2;
    logic [31:0] rd2;
    logic        rd2_unwr;

    int total = 0;
    int bad   = 0;

    logic [31:0] m_mem [32];
    logic        m_wr  [32];
    logic [31:0] e_rd1, e_rd2;
    logic        e_u1, e_u2;

    regfile32 dut (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .we       (we),
        .wa       (wa),
        .wd       (wd),
        .re1      (re1),
        .ra1      (ra1),
        .rd1      (rd1),
        .rd1_unwr (rd1_unwr),
        .re2      (re2),
        .ra2      (ra2),
        .rd2      (rd2),
        .rd2_unwr (rd2_unwr)
    );

    always #5 clk_in = ~clk_in;

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_mem[i] = '0;
            m_wr[i]  = (i == 0);
        end
        e_rd1 = '0; e_u1 = 1'b0;
        e_rd2 = '0; e_u2 = 1'b0;
    endtask

    // Reference behaviour: reads see the pre-edge contents, except a same-edge
    // write to the same nonzero address wins; r0 always reads as zero.
    task automatic model_edge();
        if (!rst_in) return;
        if (re1) begin
            if (ra1 == 0)                  begin e_rd1 = 0;         e_u1 = 0; end
            else if (we && wa == ra1)      begin e_rd1 = wd;        e_u1 = 0; end
            else                           begin e_rd1 = m_mem[ra1]; e_u1 = !m_wr[ra1]; end
        end
        if (re2) begin
            if (ra2 == 0)                  begin e_rd2 = 0;         e_u2 = 0; end
            else if (we && wa == ra2)      begin e_rd2 = wd;        e_u2 = 0; end
            else                           begin e_rd2 = m_mem[ra2]; e_u2 = !m_wr[ra2]; end
        end
        if (we && wa != 0) begin
            m_mem[wa] = wd;
            m_wr[wa]  = 1'b1;
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        model_edge();
        #1;
    endtask

    task automatic idle();
        we = 0; wa = 0; wd = 0; re1 = 0; ra1 = 0; re2 = 0; ra2 = 0;
    endtask

    task automatic test_reset();
        idle();
        rst_in = 1'b0;
        model_reset();
        repeat (2) @(posedge clk_in);
        #1;
        total++;
        if (rd1 !== 32'h0 || rd1_unwr !== 1'b0 || rd2 !== 32'h0 || rd2_unwr !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs: rd1=%h u1=%b rd2=%h u2=%b want all zero", rd1, rd1_unwr, rd2, rd2_unwr);
        end
        rst_in = 1'b1;
        #1;
        re1 = 1; ra1 = 5; re2 = 1; ra2 = 0;
        step();
        total++;
        if (rd1 !== 32'h0 || rd1_unwr !== 1'b1) begin
            bad++;
            $display("FAIL reset_read_unwr: rd1=%h u1=%b want 0/1", rd1, rd1_unwr);
        end
        total++;
        if (rd2 !== 32'h0 || rd2_unwr !== 1'b0) begin
            bad++;
            $display("FAIL reset_read_r0: rd2=%h u2=%b want 0/0", rd2, rd2_unwr);
        end
        idle();
    endtask

    task automatic test_write_read();
        we = 1; wa = 7; wd = 32'hDEADBEEF;
        step();
        idle();
        re1 = 1; ra1 = 7;
        step();
        total++;
        if (rd1 !== 32'hDEADBEEF || rd1_unwr !== 1'b0) begin
            bad++;
            $display("FAIL write_then_read: rd1=%h u1=%b want deadbeef/0", rd1, rd1_unwr);
        end
        idle();
    endtask

    task automatic test_bypass();
        we = 1; wa = 3; wd = 32'h12345678;
        re1 = 1; ra1 = 3; re2 = 1; ra2 = 3;
        step();
        total++;
        if (rd1 !== 32'h12345678 || rd1_unwr !== 1'b0) begin
            bad++;
            $display("FAIL bypass_p1: rd1=%h u1=%b want 12345678/0", rd1, rd1_unwr);
        end
        total++;
        if (rd2 !== 32'h12345678 || rd2_unwr !== 1'b0) begin
            bad++;
            $display("FAIL bypass_p2: rd2=%h u2=%b want 12345678/0", rd2, rd2_unwr);
        end
        idle();
    endtask

    task automatic test_zero_reg();
        we = 1; wa = 0; wd = 32'hFFFFFFFF;
        re2 = 1; ra2 = 0;
        step();
        total++;
        if (rd2 !== 32'h0 || rd2_unwr !== 1'b0) begin
            bad++;
            $display("FAIL r0_bypass_blocked: rd2=%h u2=%b want 0/0", rd2, rd2_unwr);
        end
        idle();
        re1 = 1; ra1 = 0;
        step();
        total++;
        if (rd1 !== 32'h0 || rd1_unwr !== 1'b0) begin
            bad++;
            $display("FAIL r0_read: rd1=%h u1=%b want 0/0", rd1, rd1_unwr);
        end
        idle();
    endtask

    task automatic test_hold();
        re1 = 1; ra1 = 7;
        step();
        re1 = 0; ra1 = 3;
        for (int c = 0; c < 3; c++) begin
            step();
            total++;
            if (rd1 !== 32'hDEADBEEF || rd1_unwr !== 1'b0) begin
                bad++;
                $display("FAIL hold_cycle%0d: rd1=%h u1=%b want deadbeef/0", c, rd1, rd1_unwr);
            end
        end
        idle();
    endtask

    task automatic test_random();
        int errs = 0;
        for (int n = 0; n < 400; n++) begin
            we  = ($urandom_range(0, 3) != 0);
            wa  = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
            wd  = $urandom;
            re1 = ($urandom_range(0, 4) != 0);
            ra1 = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
            re2 = ($urandom_range(0, 4) != 0);
            ra2 = ($urandom_range(0, 3) == 0) ? ra1 : 5'($urandom);
            step();
            total++;
            if (rd1 !== e_rd1 || rd1_unwr !== e_u1 || rd2 !== e_rd2 || rd2_unwr !== e_u2) begin
                bad++;
                if (errs++ < 10)
                    $display("FAIL random_%0d: rd1=%h/%b rd2=%h/%b want %h/%b %h/%b",
                             n, rd1, rd1_unwr, rd2, rd2_unwr, e_rd1, e_u1, e_rd2, e_u2);
            end
        end
        idle();
    endtask

    task automatic test_async_reset();
        for (int a = 1; a < 32; a++) begin
            we = 1; wa = 5'(a); wd = 32'(a);
            step();
        end
        idle();
        re1 = 1; ra1 = 5; re2 = 1; ra2 = 6;
        step();
        total++;
        if (rd1 !== 32'd5 || rd2 !== 32'd6 || rd1_unwr !== 1'b0 || rd2_unwr !== 1'b0) begin
            bad++;
            $display("FAIL prefill_read: rd1=%h rd2=%h want 5/6 flags 0", rd1, rd2);
        end
        idle();
        #2;
        rst_in = 1'b0;
        model_reset();
        #1;
        total++;
        if (rd1 !== 32'h0 || rd2 !== 32'h0 || rd1_unwr !== 1'b0 || rd2_unwr !== 1'b0) begin
            bad++;
            $display("FAIL async_clear: rd1=%h rd2=%h want 0/0 immediately", rd1, rd2);
        end
        // Writes attempted while reset is held must not land.
        we = 1; wa = 31; wd = 32'hCAFEF00D;
        @(posedge clk_in);
        #2;
        idle();
        rst_in = 1'b1;
        #1;
        re1 = 1; ra1 = 31; re2 = 1; ra2 = 31;
        step();
        total++;
        if (rd1 !== 32'h0 || rd1_unwr !== 1'b1) begin
            bad++;
            $display("FAIL post_reset_r31_p1: rd1=%h u1=%b want 0/1", rd1, rd1_unwr);
        end
        total++;
        if (rd2 !== 32'h0 || rd2_unwr !== 1'b1) begin
            bad++;
            $display("FAIL post_reset_r31_p2: rd2=%h u2=%b want 0/1", rd2, rd2_unwr);
        end
        idle();
    endtask

    initial begin
        rst_in = 1'b1;
        idle();
        #1;
        test_reset();
        test_write_read();
        test_bypass();
        test_zero_reg();
        test_hold();
        test_random();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
